// File: rtl/btn_repeat_arbiter.sv
// Time-set button arbiter: one owner at a time, step pulse on fresh press, auto-repeat after hold.
// Optional BTN_REPEAT_ACCEL_EN halves the repeat interval after 8 repeat pulses until release.
module btn_repeat_arbiter #(
    parameter int NUM_BTN      = 3,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter int CNT_W        = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] step_pulse,
    output logic [NUM_BTN-1:0] owner,
    output logic               busy,
    output logic               repeating
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_BTN-1:0] r_prev_level;
    logic [NUM_BTN-1:0] r_step;
    logic [NUM_BTN-1:0] r_owner;
    logic               r_busy;
    logic               r_repeating;

    logic [NUM_BTN-1:0] w_fresh;
    logic [NUM_BTN-1:0] w_grant;
    logic               w_owner_held;
    logic [CNT_W-1:0]   w_rep_last;
    logic               w_hold_done;
    logic               w_rep_done;

    assign w_fresh      = btn_level & ~r_prev_level;
    // Isolate the lowest set bit: lowest-index fresh press wins.
    assign w_grant      = w_fresh & (~w_fresh + NUM_BTN'(1));
    assign w_owner_held = |(btn_level & r_owner);

`ifdef BTN_REPEAT_ACCEL_EN
    localparam int               FAST_TICKS = (REPEAT_TICKS / 2 > 1) ? REPEAT_TICKS / 2 : 1;
    localparam logic [CNT_W-1:0] FAST_LAST  = CNT_W'(FAST_TICKS - 1);

    logic [3:0] r_rep_cnt;

    assign w_rep_last = r_rep_cnt[3] ? FAST_LAST : REP_LAST;

    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE) begin
            r_rep_cnt <= 4'd0;
        end else if (w_owner_held && (w_hold_done || w_rep_done) && r_rep_cnt != 4'hF) begin
            r_rep_cnt <= r_rep_cnt + 4'd1;
        end
    end
`else
    assign w_rep_last = REP_LAST;
`endif

    assign w_hold_done = tick && (r_state == S_HOLD)   && (r_cnt == HOLD_LAST);
    // >= guards the moment the interval shortens while the counter is mid-way.
    assign w_rep_done  = tick && (r_state == S_REPEAT) && (r_cnt >= w_rep_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_prev_level <= '1;
            r_step       <= '0;
            r_owner      <= '0;
            r_busy       <= 1'b0;
            r_repeating  <= 1'b0;
        end else begin
            r_prev_level <= btn_level;
            r_step       <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|w_fresh) begin
                        r_owner <= w_grant;
                        r_step  <= w_grant;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD, S_REPEAT: begin
                    // Release beats a coincident terminal tick.
                    if (!w_owner_held) begin
                        r_owner     <= '0;
                        r_busy      <= 1'b0;
                        r_repeating <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                    end else if (w_hold_done || w_rep_done) begin
                        r_step      <= r_owner;
                        r_cnt       <= '0;
                        r_repeating <= 1'b1;
                        r_state     <= S_REPEAT;
                    end else if (tick) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_owner     <= '0;
                    r_busy      <= 1'b0;
                    r_repeating <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign step_pulse = r_step;
    assign owner      = r_owner;
    assign busy       = r_busy;
    assign repeating  = r_repeating;

endmodule

// File: tb/tb_btn_repeat_arbiter.sv
// Directed bench for btn_repeat_arbiter with HOLD_TICKS=4, REPEAT_TICKS=2, NUM_BTN=3.
module tb_btn_repeat_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [2:0] btn_level = 3'b000;
    logic [2:0] step_pulse;
    logic [2:0] owner;
    logic       busy;
    logic       repeating;

    int n_chk = 0;
    int n_bad = 0;

    btn_repeat_arbiter #(
        .NUM_BTN(3), .HOLD_TICKS(4), .REPEAT_TICKS(2), .CNT_W(10)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_level(btn_level),
        .step_pulse(step_pulse), .owner(owner), .busy(busy), .repeating(repeating)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs, let one rising edge sample them, look at outputs 1ns later.
    task automatic drive(input logic [2:0] b, input logic t);
        btn_level = b;
        tick      = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pmask;
        logic [31:0] rmask;
        logic [2:0]  por;
        int          busy_cnt;
        int          pulse_cnt;
        logic        rep_seen;

        // reset
        drive(3'b000, 1'b0);
        drive(3'b000, 1'b0);
        check("reset_outs", {22'd0, step_pulse, owner, busy, repeating}, 32'd0);
        rst = 1'b0;
        drive(3'b000, 1'b0);
        check("idle_after_reset", {24'd0, owner, busy, repeating}, 32'd0);

        // 1: short press
        drive(3'b001, 1'b0);
        check("t1_step", step_pulse, 3'b001);
        check("t1_owner", owner, 3'b001);
        busy_cnt  = busy ? 1 : 0;
        pulse_cnt = (step_pulse != 0) ? 1 : 0;
        rep_seen  = repeating;
        drive(3'b001, 1'b1);
        busy_cnt += busy ? 1 : 0; pulse_cnt += (step_pulse != 0) ? 1 : 0; rep_seen |= repeating;
        drive(3'b001, 1'b0);
        busy_cnt += busy ? 1 : 0; pulse_cnt += (step_pulse != 0) ? 1 : 0; rep_seen |= repeating;
        drive(3'b000, 1'b1);
        busy_cnt += busy ? 1 : 0; pulse_cnt += (step_pulse != 0) ? 1 : 0; rep_seen |= repeating;
        check("t1_busy_cycles", busy_cnt, 3);
        check("t1_pulse_count", pulse_cnt, 1);
        check("t1_rep_seen", rep_seen, 1'b0);
        check("t1_owner_rel", owner, 3'b000);

        // 2: hold btn1 for 30 cycles, tick on odd cycles
        pmask = '0; rmask = '0; por = '0;
        for (int k = 0; k < 30; k++) begin
            drive(3'b010, (k % 2) == 1);
            if (step_pulse != 3'b000) pmask[k] = 1'b1;
            if (repeating) rmask[k] = 1'b1;
            por |= step_pulse;
        end
        check("t2_pulse_mask", pmask, 32'h0888_8881);
        check("t2_rep_mask", rmask, 32'h3FFF_FF80);
        check("t2_pulse_bits", por, 3'b010);
        drive(3'b000, 1'b0);
        check("t2_release", {29'd0, busy, repeating, step_pulse != 3'b000}, 32'd0);

        // 3: simultaneous press, non-owner ignored, no grant without fresh edge
        drive(3'b110, 1'b0);
        check("t3_owner", owner, 3'b010);
        check("t3_step", step_pulse, 3'b010);
        drive(3'b111, 1'b0);
        check("t3_nonowner_ign", {owner, step_pulse}, {3'b010, 3'b000});
        drive(3'b101, 1'b0);
        check("t3_rel_idle", {owner, busy}, {3'b000, 1'b0});
        drive(3'b101, 1'b0);
        check("t3_no_regrant", {owner, step_pulse}, 6'd0);
        drive(3'b000, 1'b0);
        drive(3'b100, 1'b0);
        check("t3_repress", {owner, step_pulse}, {3'b100, 3'b100});
        drive(3'b000, 1'b0);

        // 4: reset while repeating with a button held
        drive(3'b100, 1'b0);
        for (int k = 0; k < 4; k++) drive(3'b100, 1'b1);
        check("t4_in_repeat", {repeating, step_pulse}, {1'b1, 3'b100});
        rst = 1'b1;
        drive(3'b100, 1'b0);
        check("t4_rst_outs", {22'd0, step_pulse, owner, busy, repeating}, 32'd0);
        rst = 1'b0;
        drive(3'b100, 1'b0);
        check("t4_held_no_grant", {step_pulse, owner}, 6'd0);
        drive(3'b000, 1'b0);
        drive(3'b100, 1'b0);
        check("t4_repress", step_pulse, 3'b100);

        // 5: release on the terminal hold tick
        for (int k = 0; k < 3; k++) drive(3'b100, 1'b1);
        check("t5_pre_term", {step_pulse, busy}, {3'b000, 1'b1});
        drive(3'b000, 1'b1);
        check("t5_rel_term", {step_pulse, owner, busy, repeating}, 8'd0);
        drive(3'b000, 1'b1);
        check("t5_after", {step_pulse, busy}, 4'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
